// File: rtl/mem_access_unit.sv
// Sequential load/store unit: turns datapath load/store requests into handshaked
// bus cycles, stalls the core while a cycle is outstanding, and aligns load data.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  MemSize,
  input  logic        MemSigned,
  input  logic [31:0] Addr,
  input  logic [31:0] Rt_data,
  output logic [31:0] Load_data,
  output logic        Stall,
  output logic        Mem_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [1:0]  lane_q;
  logic        bus_req_q, bus_we_q, mem_err_q;
  logic [31:0] bus_addr_q, bus_wdata_q, load_data_q;
  logic [3:0]  bus_be_q;

  logic        req_d, fault_d;
  logic [3:0]  be_d;
  logic [31:0] wdata_d, load_ext_d;
  logic [7:0]  rd_byte_d;
  logic [15:0] rd_half_d;

  assign Load_data = load_data_q;
  assign Mem_err   = mem_err_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;

  always_comb begin
    req_d   = MemRead | MemWrite;
    fault_d = (MemRead & MemWrite) | (MemSize == 2'b11) |
              ((MemSize == 2'b01) & Addr[0]) |
              ((MemSize == 2'b10) & (Addr[1:0] != 2'b00));
    be_d    = 4'b1111;
    wdata_d = Rt_data;
    case (MemSize)
      2'b00: begin
        wdata_d = {4{Rt_data[7:0]}};
        if (MemWrite) be_d = 4'b0001 << Addr[1:0];
        else          be_d = 4'b1111;
      end
      2'b01: begin
        wdata_d = {2{Rt_data[15:0]}};
        if (MemWrite) be_d = Addr[1] ? 4'b1100 : 4'b0011;
        else          be_d = 4'b1111;
      end
      default: begin
        wdata_d = Rt_data;
        be_d    = 4'b1111;
      end
    endcase
  end

  // Lane selection uses the address captured at issue, not the live datapath address.
  always_comb begin
    rd_byte_d = bus_rdata[{lane_q, 3'b000} +: 8];
    rd_half_d = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (size_q)
      2'b00:   load_ext_d = signed_q ? {{24{rd_byte_d[7]}}, rd_byte_d} : {24'h000000, rd_byte_d};
      2'b01:   load_ext_d = signed_q ? {{16{rd_half_d[15]}}, rd_half_d} : {16'h0000, rd_half_d};
      default: load_ext_d = bus_rdata;
    endcase
  end

  always_comb begin
    Stall = 1'b0;
    if (reset) begin
      Stall = 1'b0;
    end else begin
      case (state_q)
        IDLE:    Stall = req_d;
        REQ:     Stall = 1'b1;
        default: Stall = 1'b0;
      endcase
    end
  end

  // Mem_err defaults low every cycle so it can only pulse during the single DONE cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      size_q      <= 2'b00;
      signed_q    <= 1'b0;
      lane_q      <= 2'b00;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_be_q    <= 4'h0;
      bus_wdata_q <= 32'h0;
      load_data_q <= 32'h0;
      mem_err_q   <= 1'b0;
    end else begin
      mem_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_d && fault_d) begin
            mem_err_q <= 1'b1;
            state_q   <= DONE;
          end else if (req_d) begin
            bus_addr_q  <= {Addr[31:2], 2'b00};
            bus_we_q    <= MemWrite;
            bus_be_q    <= be_d;
            bus_wdata_q <= wdata_d;
            size_q      <= MemSize;
            signed_q    <= MemSigned;
            lane_q      <= Addr[1:0];
            cnt_q       <= 8'd0;
            bus_req_q   <= 1'b1;
            state_q     <= REQ;
          end
        end
        REQ: begin
          if (bus_ack) begin
            if (!bus_we_q) load_data_q <= load_ext_d;
            bus_req_q <= 1'b0;
            state_q   <= DONE;
          end else if (cnt_q == 8'(TIMEOUT - 1)) begin
            bus_req_q <= 1'b0;
            mem_err_q <= 1'b1;
            state_q   <= DONE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          bus_req_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: the driver queues expected bus cycles and
// completions, and a negedge monitor pops and compares them as the DUT presents them.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite, MemSigned;
  logic [1:0]  MemSize;
  logic [31:0] Addr, Rt_data, Load_data, bus_addr, bus_wdata, bus_rdata;
  logic        Stall, Mem_err, bus_req, bus_we, bus_ack;
  logic [3:0]  bus_be;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] load;
    logic        err;
    int          stall_cycles;
    int          req_cycles;
  } done_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } bus_t;

  done_t done_q[$];
  bus_t  bus_q[$];

  mem_access_unit #(.TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemSize(MemSize), .MemSigned(MemSigned), .Addr(Addr), .Rt_data(Rt_data),
    .Load_data(Load_data), .Stall(Stall), .Mem_err(Mem_err), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic expect_done(input logic [31:0] load, input logic err, input int st, input int rq);
    done_t d;
    d.load = load; d.err = err; d.stall_cycles = st; d.req_cycles = rq;
    done_q.push_back(d);
  endtask

  task automatic expect_bus(input logic [31:0] a, input logic [3:0] be, input logic we, input logic [31:0] wd);
    bus_t b;
    b.addr = a; b.be = be; b.we = we; b.wdata = wd;
    bus_q.push_back(b);
  endtask

  // Monitor: bus-cycle contents and stability, and completion (first non-stalled cycle after a stall).
  logic  prev_stall = 1'b0;
  logic  bus_active = 1'b0;
  int    stall_cnt = 0;
  int    req_cnt = 0;
  bus_t  cur_bus;
  done_t cur_done;

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
      bus_active = 1'b0;
      stall_cnt  = 0;
      req_cnt    = 0;
    end else begin
      if (bus_req) begin
        if (!bus_active) begin
          if (bus_q.size() == 0) begin
            errors++; checks++;
            $display("FAIL unexpected_bus_req: got bus_req=1, expected no bus cycle");
          end else begin
            cur_bus = bus_q.pop_front();
            check("bus_addr", bus_addr, cur_bus.addr);
            check("bus_be", {28'h0, bus_be}, {28'h0, cur_bus.be});
            check("bus_we", {31'h0, bus_we}, {31'h0, cur_bus.we});
            if (cur_bus.we) check("bus_wdata", bus_wdata, cur_bus.wdata);
          end
          bus_active = 1'b1;
        end else begin
          check("bus_stable", {bus_addr[31:2], bus_be, bus_we, bus_wdata},
                {cur_bus.addr[31:2], cur_bus.be, cur_bus.we, (cur_bus.we ? cur_bus.wdata : bus_wdata)});
        end
        req_cnt++;
      end else begin
        bus_active = 1'b0;
      end
      if (Stall) stall_cnt++;
      if (prev_stall && !Stall) begin
        if (done_q.size() == 0) begin
          errors++; checks++;
          $display("FAIL unexpected_done: got completion, expected none");
        end else begin
          cur_done = done_q.pop_front();
          check("load_data", Load_data, cur_done.load);
          check("mem_err", {31'h0, Mem_err}, {31'h0, cur_done.err});
          check("stall_cycles", stall_cnt, cur_done.stall_cycles);
          check("req_cycles", req_cnt, cur_done.req_cycles);
        end
        stall_cnt = 0;
        req_cnt   = 0;
      end else if (Mem_err) begin
        errors++; checks++;
        $display("FAIL mem_err_stray: got Mem_err=1, expected 0 outside completion");
      end
      prev_stall = Stall;
    end
  end

  // Driver plus a simple memory responder acking in REQ cycle ack_at (0 = never).
  task automatic access(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, input int ack_at,
                        input logic [31:0] rdata);
    int  rc = 0;
    bit  stalled = 0;
    bit  done = 0;
    @(posedge clk); #1;
    MemRead = rd; MemWrite = wr; MemSize = sz; MemSigned = sg; Addr = a; Rt_data = wd;
    #1;
    for (int c = 0; c < 60; c++) begin
      if (bus_req) begin
        bus_ack   = (ack_at != 0) && (rc == ack_at - 1);
        bus_rdata = bus_ack ? rdata : 32'h0;
        rc++;
      end else begin
        bus_ack = 1'b0;
      end
      if (Stall) stalled = 1;
      else if (stalled) begin done = 1; break; end
      @(posedge clk); #2;
    end
    if (!done) begin
      errors++; checks++;
      $display("FAIL access_timeout: got no completion, expected one within 60 cycles");
    end
    MemRead = 1'b0; MemWrite = 1'b0; bus_ack = 1'b0; bus_rdata = 32'h0;
  endtask

  initial begin
    reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; MemSize = 2'b00; MemSigned = 1'b0;
    Addr = 32'h0; Rt_data = 32'h0; bus_rdata = 32'h0; bus_ack = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_outputs", {Load_data, bus_addr, bus_wdata}, {32'h0, 32'h0, 32'h0});
    check("rst_ctrl", {27'h0, Stall, Mem_err, bus_req, bus_we, bus_be == 4'h0},
          {27'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    @(negedge clk); reset = 1'b0;

    // word load, ack in first REQ cycle
    expect_bus(32'h10, 4'hF, 1'b0, 32'h0);
    expect_done(32'hDEADBEEF, 1'b0, 2, 1);
    access(1, 0, 2'b10, 0, 32'h10, 32'h0, 1, 32'hDEADBEEF);
    // byte loads from top lane, signed then unsigned
    expect_bus(32'h10, 4'hF, 1'b0, 32'h0);
    expect_done(32'hFFFFFF80, 1'b0, 2, 1);
    access(1, 0, 2'b00, 1, 32'h13, 32'h0, 1, 32'h80123456);
    expect_bus(32'h10, 4'hF, 1'b0, 32'h0);
    expect_done(32'h00000080, 1'b0, 2, 1);
    access(1, 0, 2'b00, 0, 32'h13, 32'h0, 1, 32'h80123456);
    // half store, upper half, ack in third REQ cycle
    expect_bus(32'h20, 4'hC, 1'b1, 32'hABCDABCD);
    expect_done(32'h00000080, 1'b0, 4, 3);
    access(0, 1, 2'b01, 0, 32'h22, 32'h1234ABCD, 3, 32'h0);
    // misaligned word load
    expect_done(32'h00000080, 1'b1, 1, 0);
    access(1, 0, 2'b10, 0, 32'h06, 32'h0, 1, 32'h0);
    // misaligned half, reserved size, both requests
    expect_done(32'h00000080, 1'b1, 1, 0);
    access(1, 0, 2'b01, 0, 32'h01, 32'h0, 1, 32'h0);
    expect_done(32'h00000080, 1'b1, 1, 0);
    access(1, 0, 2'b11, 0, 32'h00, 32'h0, 1, 32'h0);
    expect_done(32'h00000080, 1'b1, 1, 0);
    access(1, 1, 2'b10, 0, 32'h00, 32'h0, 1, 32'h0);
    // byte store lane 1, half loads
    expect_bus(32'h40, 4'h2, 1'b1, 32'h77777777);
    expect_done(32'h00000080, 1'b0, 3, 2);
    access(0, 1, 2'b00, 0, 32'h41, 32'h12345677, 2, 32'h0);
    expect_bus(32'h00, 4'hF, 1'b0, 32'h0);
    expect_done(32'hFFFF8001, 1'b0, 2, 1);
    access(1, 0, 2'b01, 1, 32'h02, 32'h0, 1, 32'h80017FFF);
    expect_bus(32'h00, 4'hF, 1'b0, 32'h0);
    expect_done(32'h0000FFFF, 1'b0, 2, 1);
    access(1, 0, 2'b01, 0, 32'h00, 32'h0, 1, 32'h8001FFFF);
    // no ack: timeout after 15 REQ cycles
    expect_bus(32'h30, 4'hF, 1'b0, 32'h0);
    expect_done(32'h0000FFFF, 1'b1, 16, 15);
    access(1, 0, 2'b10, 0, 32'h30, 32'h0, 0, 32'h0);

    // reset in the middle of a REQ phase
    expect_bus(32'h50, 4'hF, 1'b0, 32'h0);
    @(posedge clk); #1;
    MemRead = 1'b1; MemSize = 2'b10; Addr = 32'h50;
    repeat (3) @(posedge clk);
    #1;
    check("pre_reset_req", {31'h0, bus_req}, {31'h0, 1'b1});
    #1; reset = 1'b1; #1;
    check("mid_rst_ctrl", {28'h0, bus_req, Stall, Mem_err, bus_we}, 32'h0);
    check("mid_rst_bus", {bus_addr[31:4], bus_be}, 32'h0);
    check("mid_rst_load", Load_data, 32'h0);
    MemRead = 1'b0;
    @(negedge clk); @(negedge clk); reset = 1'b0;

    // store after reset completes normally
    expect_bus(32'h40, 4'hF, 1'b1, 32'hCAFEF00D);
    expect_done(32'h0, 1'b0, 3, 2);
    access(0, 1, 2'b10, 0, 32'h40, 32'hCAFEF00D, 2, 32'h0);

    repeat (3) @(posedge clk);
    check("done_q_empty", done_q.size(), 32'd0);
    check("bus_q_empty", bus_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
